// File: rtl/boot_copy_ctrl.sv
// boot_copy_ctrl: start-up sequencer for the RockWave core.
// Keeps the core in reset while the data-memory image is copied from
// instruction ROM into data RAM, one word per cycle. It then releases the
// core and hands both memory ports over to it.
// Optional feature macro: BOOT_CHECKSUM_EN. When it is defined, a running
// sum of every copied word is built. When it is not defined, boot_checksum
// is tied to 0.
// Memory handshake: there is no valid/ready. A ROM read address is
// accepted at every edge and its data appears one cycle later. A RAM write
// commits at the edge where ram_we equals WE_WORD.
module boot_copy_ctrl #(
  parameter int unsigned              AWIDTH     = 12,
  parameter int unsigned              XLEN       = 32,
  parameter logic [AWIDTH-1:0]        SRC_BASE   = 'h800,
  parameter int unsigned              COPY_BYTES = 'h800,
  parameter logic [2:0]               WE_WORD    = 3'b110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reboot,
  input  logic [AWIDTH-1:0] core_inst_addr,
  output logic [AWIDTH-1:0] inst_addr,
  input  logic [AWIDTH-1:0] core_data_addr,
  input  logic [XLEN-1:0]   core_data_wdata,
  input  logic [2:0]        core_data_we,
  input  logic [XLEN-1:0]   rom_data,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [2:0]        ram_we,
  output logic              core_rst_n,
  output logic              boot_busy,
  output logic              boot_done,
  output logic [XLEN-1:0]   boot_checksum,
  output logic [1:0]        dbg_state
);

  localparam int unsigned     OFFW     = $clog2(COPY_BYTES + 1);
  localparam logic [OFFW-1:0] COPY_END = OFFW'(COPY_BYTES);
  localparam logic [OFFW-1:0] STEP     = OFFW'(4);

  typedef enum logic [1:0] {
    COPY    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state_q;
  logic [OFFW-1:0] rd_off_q;
  logic [OFFW-1:0] wr_off_q;
  logic            wr_valid_q;
  logic            core_rst_n_q;
  logic            boot_busy_q;
  logic            boot_done_q;

  // Sequencer. It has two pipeline stages: read ROM at rd_off, then write
  // RAM at wr_off. The outputs to the core are registered, so core_rst_n
  // cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COPY;
      rd_off_q     <= '0;
      wr_off_q     <= '0;
      wr_valid_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      boot_busy_q  <= 1'b1;
      boot_done_q  <= 1'b0;
    end else begin
      case (state_q)
        COPY: begin
          if (rd_off_q < COPY_END) rd_off_q <= rd_off_q + STEP;
          wr_valid_q <= (rd_off_q < COPY_END);
          wr_off_q   <= rd_off_q;
          // The read side has finished, and the last word is on the write
          // port now. It commits at this edge.
          if (wr_valid_q && (rd_off_q == COPY_END)) state_q <= RELEASE;
        end
        RELEASE: begin
          state_q      <= RUN;
          core_rst_n_q <= 1'b1;
          boot_busy_q  <= 1'b0;
          boot_done_q  <= 1'b1;
        end
        RUN: begin
          if (reboot) begin
            state_q      <= COPY;
            rd_off_q     <= '0;
            wr_off_q     <= '0;
            wr_valid_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            boot_busy_q  <= 1'b1;
            boot_done_q  <= 1'b0;
          end
        end
        default: state_q <= COPY;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [XLEN-1:0] checksum_q;

  // Sum of the copied words, modulo 2^XLEN. It holds its value after the
  // copy finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (state_q == RUN && reboot) begin
      checksum_q <= '0;
    end else if (state_q == COPY && wr_valid_q) begin
      checksum_q <= checksum_q + rom_data;
    end
  end

  assign boot_checksum = checksum_q;
`else
  assign boot_checksum = '0;
`endif

  // Port arbitration. The loader owns both memories until RUN. After that,
  // the core signals pass straight through.
  always_comb begin
    inst_addr = SRC_BASE + AWIDTH'(rd_off_q);
    ram_addr  = AWIDTH'(wr_off_q);
    ram_wdata = rom_data;
    ram_we    = 3'b000;
    case (state_q)
      COPY:    ram_we = wr_valid_q ? WE_WORD : 3'b000;
      RUN: begin
        inst_addr = core_inst_addr;
        ram_addr  = core_data_addr;
        ram_wdata = core_data_wdata;
        ram_we    = core_data_we;
      end
      default: ram_we = 3'b000;
    endcase
  end

  assign core_rst_n = core_rst_n_q;
  assign boot_busy  = boot_busy_q;
  assign boot_done  = boot_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl with behavioural ROM and RAM models.
module tb_boot_copy_ctrl;

  logic        clk;
  logic        rst_n;
  logic        reboot;
  logic [11:0] core_inst_addr;
  logic [11:0] inst_addr;
  logic [11:0] core_data_addr;
  logic [31:0] core_data_wdata;
  logic [2:0]  core_data_we;
  logic [31:0] rom_data;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [2:0]  ram_we;
  logic        core_rst_n;
  logic        boot_busy;
  logic        boot_done;
  logic [31:0] boot_checksum;
  logic [1:0]  dbg_state;

  logic [31:0] rom_mem [0:1023];
  logic [31:0] ram_mem [0:1023];
  logic [11:0] last_wr_addr;
  logic [31:0] exp_ck;
  int          total;
  int          bad;

  boot_copy_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reboot          (reboot),
    .core_inst_addr  (core_inst_addr),
    .inst_addr       (inst_addr),
    .core_data_addr  (core_data_addr),
    .core_data_wdata (core_data_wdata),
    .core_data_we    (core_data_we),
    .rom_data        (rom_data),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .core_rst_n      (core_rst_n),
    .boot_busy       (boot_busy),
    .boot_done       (boot_done),
    .boot_checksum   (boot_checksum),
    .dbg_state       (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM, word addressed
  always @(posedge clk) rom_data <= rom_mem[inst_addr[11:2]];

  // RAM: full-word writes only
  always @(posedge clk) begin
    if (ram_we == 3'b110) begin
      ram_mem[ram_addr[11:2]] <= ram_wdata;
      last_wr_addr            <= ram_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs edges 1..stop_at of a copy. Edge 1 is the first edge after reset
  // release or after the reboot edge. A reboot pulse can be injected during
  // COPY, where it must be ignored.
  task automatic run_copy(input int stop_at, input int reboot_at);
    for (int e = 1; e <= stop_at; e++) begin
      @(posedge clk);
      #1;
      if (e <= 512) begin
        check("cp_we",    {29'd0, ram_we}, 32'd6);
        check("cp_addr",  {20'd0, ram_addr}, (e - 1) * 4);
        check("cp_wdata", ram_wdata, rom_mem[(511 + e) % 1024]);
        check("cp_iaddr", {20'd0, inst_addr}, (32'h800 + 4 * e) % 4096);
        check("cp_rst",   {31'd0, core_rst_n}, 32'd0);
        check("cp_busy",  {31'd0, boot_busy}, 32'd1);
      end else if (e == 513) begin
        check("rel_we",    {29'd0, ram_we}, 32'd0);
        check("rel_rst",   {31'd0, core_rst_n}, 32'd0);
        check("rel_busy",  {31'd0, boot_busy}, 32'd1);
        check("rel_done",  {31'd0, boot_done}, 32'd0);
        check("rel_state", {30'd0, dbg_state}, 32'd1);
      end else begin
        check("run_rst",   {31'd0, core_rst_n}, 32'd1);
        check("run_done",  {31'd0, boot_done}, 32'd1);
        check("run_busy",  {31'd0, boot_busy}, 32'd0);
        check("run_state", {30'd0, dbg_state}, 32'd2);
        check("run_ck",    boot_checksum, exp_ck);
        core_data_we = 3'b000;
      end
      if (e == 2) check("first_wr", {20'd0, last_wr_addr}, 32'd0);
      reboot = (e == reboot_at);
    end
    reboot = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
    rom_mem[512]  = 32'hDEADBEEF;
    rom_mem[1023] = 32'h12345678;
    exp_ck = 32'd0;
`ifdef BOOT_CHECKSUM_EN
    for (int i = 512; i < 1024; i++) exp_ck = exp_ck + rom_mem[i];
`endif

    rst_n           = 1'b0;
    reboot          = 1'b0;
    core_inst_addr  = 12'h000;
    core_data_addr  = 12'h010;
    core_data_wdata = 32'hAAAA5555;
    core_data_we    = 3'b110;
    repeat (3) @(posedge clk);
    #1;

    // reset state, with the core trying to write
    check("rst_we",    {29'd0, ram_we}, 32'd0);
    check("rst_crst",  {31'd0, core_rst_n}, 32'd0);
    check("rst_busy",  {31'd0, boot_busy}, 32'd1);
    check("rst_done",  {31'd0, boot_done}, 32'd0);
    check("rst_ck",    boot_checksum, 32'd0);
    check("rst_iaddr", {20'd0, inst_addr}, 32'h800);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // first boot: core inputs active, and a stray reboot in COPY
    @(negedge clk);
    rst_n = 1'b1;
    run_copy(514, 50);
    check("ram_first", ram_mem[0], 32'hDEADBEEF);
    check("ram_last",  ram_mem[511], 32'h12345678);
    check("ram_0x10",  ram_mem[4], rom_mem[516]);

    // RUN pass-through
    core_data_addr  = 12'h020;
    core_data_wdata = 32'h0BADF00D;
    core_data_we    = 3'b110;
    core_inst_addr  = 12'h123;
    #1;
    check("pt_addr",  {20'd0, ram_addr}, 32'h020);
    check("pt_wdata", ram_wdata, 32'h0BADF00D);
    check("pt_we",    {29'd0, ram_we}, 32'd6);
    check("pt_iaddr", {20'd0, inst_addr}, 32'h123);
    @(posedge clk);
    #1;
    core_data_we = 3'b000;
    check("pt_ram",    ram_mem[8], 32'h0BADF00D);
    check("pt_ck_frz", boot_checksum, exp_ck);

    // reboot in RUN
    reboot = 1'b1;
    @(posedge clk);
    #1;
    reboot = 1'b0;
    check("rb_crst", {31'd0, core_rst_n}, 32'd0);
    check("rb_busy", {31'd0, boot_busy}, 32'd1);
    check("rb_done", {31'd0, boot_done}, 32'd0);
    check("rb_ck",   boot_checksum, 32'd0);
    run_copy(514, 0);
    check("rb_ram20", ram_mem[8], rom_mem[520]);

    // reboot, then assert rst_n between edges 100 and 101
    reboot = 1'b1;
    @(posedge clk);
    #1;
    reboot = 1'b0;
    run_copy(100, 0);
    rst_n = 1'b0;
    #1;
    check("ar_we",    {29'd0, ram_we}, 32'd0);
    check("ar_crst",  {31'd0, core_rst_n}, 32'd0);
    check("ar_busy",  {31'd0, boot_busy}, 32'd1);
    check("ar_ck",    boot_checksum, 32'd0);
    check("ar_iaddr", {20'd0, inst_addr}, 32'h800);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_copy(514, 0);
    check("ar_ram0",  ram_mem[0], 32'hDEADBEEF);
    check("ar_ram20", ram_mem[8], rom_mem[520]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
